// File: rtl/cla_pkg.sv
// cla_pkg: op encoding and parameter-legality helpers shared by the CLA pipe.
package cla_pkg;

  typedef enum logic {
    CLA_ADD = 1'b0,
    CLA_SUB = 1'b1
  } cla_op_e;

  localparam int CLA_MIN_WIDTH = 4;
  localparam int CLA_MAX_WIDTH = 64;

  function automatic bit cla_legal(int width, int block);
    bit blk_ok;
    blk_ok = (block == 2) || (block == 4) || (block == 8);
    return blk_ok
      && (width >= CLA_MIN_WIDTH)
      && (width <= CLA_MAX_WIDTH)
      && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/module_cla_group.sv
// module_cla_group: BLOCK-bit combinational lookahead group.
// Produces group sum for a given carry-in plus group propagate/generate.
module module_cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             p_o,
  output logic             g_o
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum_o = p ^ c[BLOCK-1:0];

  always_comb begin
    g_o = 1'b0;
    p_o = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      g_o = g[i] | (p[i] & g_o);
      p_o = p_o & p[i];
    end
  end

endmodule

// File: rtl/module_cla_pipe.sv
// module_cla_pipe: 2-stage carry-lookahead add/sub with valid/ready flow.
// Optional signed-overflow flag enabled by defining CLA_OVERFLOW_EN.
module module_cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             valid_pi,
  output logic             ready_po,
  input  logic             op_pi,
  input  logic [WIDTH-1:0] a_pi,
  input  logic [WIDTH-1:0] b_pi,
  input  logic             cin_pi,
  output logic             valid_po,
  input  logic             ready_pi,
  output logic [WIDTH:0]   result_po,
  output logic             ovf_po
);

  localparam int NG = WIDTH / BLOCK;

  if (!cla_legal(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("module_cla_pipe: illegal WIDTH/BLOCK combination");
  end

  cla_op_e          op_in;
  logic [WIDTH-1:0] b_inv;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [WIDTH-1:0] unused_s1_sum;

  logic             s1_valid_q, s1_valid_d;
  cla_op_e          s1_op_q;
  logic             s1_cin_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [NG-1:0]    s1_p_q;
  logic [NG-1:0]    s1_g_q;

  logic             valid_q, valid_d;
  logic [WIDTH:0]   res_q, res_d;

  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum;
  logic [NG-1:0]    unused_s2_p;
  logic [NG-1:0]    unused_s2_g;

  logic s1_adv, ready, accept, s2_load;

  assign op_in = cla_op_e'(op_pi);
  assign b_inv = b_pi ^ {WIDTH{op_pi}};

  always_comb begin
    s1_adv     = !valid_q | ready_pi;
    ready      = !s1_valid_q | s1_adv;
    accept     = valid_pi & ready;
    s2_load    = s1_adv & s1_valid_q;
    s1_valid_d = ready ? valid_pi : s1_valid_q;
    valid_d    = s1_adv ? s1_valid_q : valid_q;
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    module_cla_group #(.BLOCK(BLOCK)) u_pg (
      .a_i   (a_pi[k*BLOCK +: BLOCK]),
      .b_i   (b_inv[k*BLOCK +: BLOCK]),
      .cin_i (1'b0),
      .sum_o (unused_s1_sum[k*BLOCK +: BLOCK]),
      .p_o   (grp_p[k]),
      .g_o   (grp_g[k])
    );

    module_cla_group #(.BLOCK(BLOCK)) u_sum (
      .a_i   (s1_a_q[k*BLOCK +: BLOCK]),
      .b_i   (s1_b_q[k*BLOCK +: BLOCK]),
      .cin_i (gc[k]),
      .sum_o (sum[k*BLOCK +: BLOCK]),
      .p_o   (unused_s2_p[k]),
      .g_o   (unused_s2_g[k])
    );
  end

  // Group-level carry chain over the P/G captured in S1.
  always_comb begin
    gc    = '0;
    gc[0] = (s1_op_q == CLA_SUB) ? 1'b1 : s1_cin_q;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = s1_g_q[k] | (s1_p_q[k] & gc[k]);
    end
    res_d = {gc[NG], sum};
  end

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= CLA_ADD;
      s1_cin_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q  <= op_in;
        s1_cin_q <= cin_pi;
        s1_a_q   <= a_pi;
        s1_b_q   <= b_inv;
        s1_p_q   <= grp_p;
        s1_g_q   <= grp_g;
      end
    end
  end

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (s2_load) begin
        res_q <= res_d;
      end
    end
  end

`ifdef CLA_OVERFLOW_EN
  logic c_msb_in;
  logic ovf_q, ovf_d;

  // Carry into the MSB recovered from its sum bit and operand bits.
  assign c_msb_in = sum[WIDTH-1] ^ s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1];
  assign ovf_d    = gc[NG] ^ c_msb_in;

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      ovf_q <= 1'b0;
    end else if (s2_load) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_po = ovf_q;
`else
  assign ovf_po = 1'b0;
`endif

  assign ready_po  = ready;
  assign valid_po  = valid_q;
  assign result_po = res_q;

endmodule
